// File: rtl/pcx_arb_dest_if.sv
// PCX source/destination bundle for one per-destination arbiter.
// slave: arbiter side (reqs/atom/stall in, queue controls, grants, err out).
interface pcx_arb_dest_if #(
  parameter int NSRC = 5
);
  logic [NSRC-1:0] spc_pcx_req_pq;
  logic [NSRC-1:0] spc_pcx_atom_pq;
  logic            sctag_pcx_stall_pq;
  logic [NSRC-1:0] arb_pcxdp_grant_pa;
  logic [NSRC-1:0] arb_pcxdp_q0_hold_pa_l;
  logic [NSRC-1:0] arb_pcxdp_qsel0_pa;
  logic [NSRC-1:0] arb_pcxdp_qsel1_pa_l;
  logic [NSRC-1:0] arb_pcxdp_shift_px;
  logic [NSRC-1:0] pcx_spc_grant_px;
  logic            arb_err;

  modport master (
    output spc_pcx_req_pq, spc_pcx_atom_pq,
    output sctag_pcx_stall_pq,
    input  arb_pcxdp_grant_pa,
    input  arb_pcxdp_q0_hold_pa_l,
    input  arb_pcxdp_qsel0_pa,
    input  arb_pcxdp_qsel1_pa_l,
    input  arb_pcxdp_shift_px,
    input  pcx_spc_grant_px, arb_err
  );

  modport slave (
    input  spc_pcx_req_pq, spc_pcx_atom_pq,
    input  sctag_pcx_stall_pq,
    output arb_pcxdp_grant_pa,
    output arb_pcxdp_q0_hold_pa_l,
    output arb_pcxdp_qsel0_pa,
    output arb_pcxdp_qsel1_pa_l,
    output arb_pcxdp_shift_px,
    output pcx_spc_grant_px, arb_err
  );
endinterface

// File: rtl/pcx_arb_dest.sv
// Per-destination PCX arbiter: tracks 2-entry source queues, round-robin
// grant with atomic-pair lock. Ports: rclk, arst_l, bus (slave).
// Optional: PCX_ARB_ERR_CHK_EN enables the sticky arb_err checker.
module pcx_arb_dest #(
  parameter int NSRC       = 5,
  parameter int RR_RST_PTR = 0
) (
  input  logic rclk,
  input  logic arst_l,
  pcx_arb_dest_if.slave bus
);
  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0] req_pa_q, req_pa_d;
  logic [NSRC-1:0] atom_pa_q, atom_pa_d;
  logic            stall_pa_q, stall_pa_d;
  logic [1:0]      cnt_q [NSRC];
  logic [1:0]      cnt_d [NSRC];
  logic [NSRC-1:0] aq0_q, aq0_d;
  logic [NSRC-1:0] aq1_q, aq1_d;
  logic            lock_q, lock_d;
  logic [PW-1:0]   lock_src_q, lock_src_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [NSRC-1:0] cred_q, cred_d;

  logic [NSRC-1:0] elig, gnt;
  logic [NSRC-1:0] qsel0, qsel1_l, shift;
  logic [NSRC-1:0] ovf, aerr;

  always_comb begin
    req_pa_d   = bus.spc_pcx_req_pq;
    atom_pa_d  = bus.spc_pcx_atom_pq;
    stall_pa_d = bus.sctag_pcx_stall_pq;
    cred_d     = gnt;
  end

  // An atomic head is only eligible once its second half is queued.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      elig[i] = (cnt_q[i] == 2'd2) |
                ((cnt_q[i] == 2'd1) & ~aq0_q[i]);
    end
  end

  // Locked second half is forced through, even under stall.
  always_comb begin
    int idx;
    int gidx;
    int nxt;
    logic hit;
    gnt        = '0;
    hit        = 1'b0;
    idx        = 0;
    gidx       = 0;
    nxt        = 0;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    rr_d       = rr_q;
    if (lock_q) begin
      gnt[lock_src_q] = 1'b1;
      hit  = 1'b1;
      gidx = int'(lock_src_q);
    end else if (!stall_pa_q) begin
      for (int k = 0; k < NSRC; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NSRC) idx = idx - NSRC;
        if (!hit && elig[idx]) begin
          gnt[idx] = 1'b1;
          hit  = 1'b1;
          gidx = idx;
        end
      end
    end
    if (hit) begin
      if (aq0_q[gidx]) begin
        lock_d     = 1'b1;
        lock_src_d = PW'(gidx);
      end else begin
        lock_d = 1'b0;
        nxt    = (gidx == NSRC - 1) ? 0 : gidx + 1;
        rr_d   = PW'(nxt);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      qsel0[i]   = req_pa_q[i] &
                   ((cnt_q[i] == 2'd0) |
                    ((cnt_q[i] == 2'd1) & gnt[i]));
      qsel1_l[i] = ~(req_pa_q[i] & ~qsel0[i]);
      shift[i]   = gnt[i] & (cnt_q[i] == 2'd2);
      ovf[i]     = req_pa_q[i] & (cnt_q[i] == 2'd2) & ~gnt[i];
      aerr[i]    = atom_pa_q[i] & (cnt_q[i] == 2'd2) & ~gnt[i];
      cnt_d[i]   = cnt_q[i];
      aq0_d[i]   = aq0_q[i];
      aq1_d[i]   = aq1_q[i];
      // Full queue with no grant: incoming packet is dropped.
      priority case (1'b1)
        shift[i]: begin
          cnt_d[i] = req_pa_q[i] ? 2'd2 : 2'd1;
          aq0_d[i] = aq1_q[i];
          aq1_d[i] = req_pa_q[i] & atom_pa_q[i];
        end
        gnt[i]: begin
          cnt_d[i] = {1'b0, req_pa_q[i]};
          aq0_d[i] = req_pa_q[i] & atom_pa_q[i];
          aq1_d[i] = 1'b0;
        end
        qsel0[i]: begin
          cnt_d[i] = 2'd1;
          aq0_d[i] = atom_pa_q[i];
        end
        (req_pa_q[i] & (cnt_q[i] == 2'd1)): begin
          cnt_d[i] = 2'd2;
          aq1_d[i] = atom_pa_q[i];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      req_pa_q   <= '0;
      atom_pa_q  <= '0;
      stall_pa_q <= 1'b0;
      aq0_q      <= '0;
      aq1_q      <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= '0;
      rr_q       <= PW'(RR_RST_PTR);
      cred_q     <= '0;
      for (int i = 0; i < NSRC; i++) cnt_q[i] <= 2'd0;
    end else begin
      req_pa_q   <= req_pa_d;
      atom_pa_q  <= atom_pa_d;
      stall_pa_q <= stall_pa_d;
      aq0_q      <= aq0_d;
      aq1_q      <= aq1_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      rr_q       <= rr_d;
      cred_q     <= cred_d;
      for (int i = 0; i < NSRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef PCX_ARB_ERR_CHK_EN
  logic err_q, err_d;

  always_comb err_d = err_q | (|ovf) | (|aerr);

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign bus.arb_err = err_q;
`else
  logic unused_err;
  assign unused_err  = (|ovf) | (|aerr);
  assign bus.arb_err = 1'b0;
`endif

  assign bus.arb_pcxdp_grant_pa     = gnt;
  assign bus.arb_pcxdp_qsel0_pa     = qsel0;
  assign bus.arb_pcxdp_qsel1_pa_l   = qsel1_l;
  assign bus.arb_pcxdp_shift_px     = shift;
  assign bus.arb_pcxdp_q0_hold_pa_l = qsel0 | shift;
  assign bus.pcx_spc_grant_px       = cred_q;
endmodule

// File: tb/tb_pcx_arb_dest.sv
// Scoreboard bench for pcx_arb_dest: per-cycle stimulus rows paired
// with hand-derived expected outputs, popped and compared at negedge.
module tb_pcx_arb_dest;
`ifdef PCX_ARB_ERR_CHK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic rclk = 1'b0;
  logic arst_l = 1'b0;
  always #5 rclk = ~rclk;

  pcx_arb_dest_if #(.NSRC(5)) bus();

  pcx_arb_dest #(.NSRC(5), .RR_RST_PTR(0)) dut (
    .rclk(rclk),
    .arst_l(arst_l),
    .bus(bus)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] req;
    logic [4:0] atom;
    logic       stall;
  } stim_t;

  typedef struct packed {
    logic [4:0] gnt;
    logic [4:0] qs0;
    logic [4:0] qs1l;
    logic [4:0] sh;
    logic       err;
  } exp_t;

  stim_t stq[$];
  exp_t  sbq[$];
  int vectors = 0;
  int miscompares = 0;

  logic [30:0] obs;
  assign obs = {bus.arb_pcxdp_grant_pa, bus.arb_pcxdp_qsel0_pa,
                bus.arb_pcxdp_qsel1_pa_l, bus.arb_pcxdp_shift_px,
                bus.arb_pcxdp_q0_hold_pa_l, bus.pcx_spc_grant_px,
                bus.arb_err};

  task automatic row(input logic rst, input logic [4:0] r, a,
                     input logic s, input logic [4:0] g, q0, q1l, sh,
                     input logic e);
    stq.push_back(stim_t'({rst, r, a, s}));
    sbq.push_back(exp_t'({g, q0, q1l, sh, e}));
  endtask

  task automatic test_reset();
    stim_t s; exp_t e; logic [30:0] w; logic [4:0] pg = '0; int c = 0;
    row(1, 5'h1f, 5'h1f, 1, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(1, 5'h1f, 5'h1f, 1, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    while (stq.size() > 0) begin
      s = stq.pop_front(); e = sbq.pop_front();
      @(posedge rclk); #1;
      arst_l = ~s.rst;
      bus.spc_pcx_req_pq = s.req;
      bus.spc_pcx_atom_pq = s.atom;
      bus.sctag_pcx_stall_pq = s.stall;
      @(negedge rclk);
      if (s.rst) pg = '0;
      w = {e.gnt, e.qs0, e.qs1l, e.sh, e.qs0 | e.sh, pg, e.err};
      pg = e.gnt;
      vectors++;
      if (obs !== w) begin
        miscompares++;
        $display("FAIL reset c%0d: got %h want %h", c, obs, w);
      end
      c++;
    end
  endtask

  task automatic test_single();
    stim_t s; exp_t e; logic [30:0] w; logic [4:0] pg = '0; int c = 0;
    row(0, 5'h04, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h04, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h04, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    while (stq.size() > 0) begin
      s = stq.pop_front(); e = sbq.pop_front();
      @(posedge rclk); #1;
      arst_l = ~s.rst;
      bus.spc_pcx_req_pq = s.req;
      bus.spc_pcx_atom_pq = s.atom;
      bus.sctag_pcx_stall_pq = s.stall;
      @(negedge rclk);
      if (s.rst) pg = '0;
      w = {e.gnt, e.qs0, e.qs1l, e.sh, e.qs0 | e.sh, pg, e.err};
      pg = e.gnt;
      vectors++;
      if (obs !== w) begin
        miscompares++;
        $display("FAIL single c%0d: got %h want %h", c, obs, w);
      end
      c++;
    end
  endtask

  task automatic test_round_robin();
    stim_t s; exp_t e; logic [30:0] w; logic [4:0] pg = '0; int c = 0;
    row(1, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h1f, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h1f, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h01, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h02, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h04, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h08, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h10, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    while (stq.size() > 0) begin
      s = stq.pop_front(); e = sbq.pop_front();
      @(posedge rclk); #1;
      arst_l = ~s.rst;
      bus.spc_pcx_req_pq = s.req;
      bus.spc_pcx_atom_pq = s.atom;
      bus.sctag_pcx_stall_pq = s.stall;
      @(negedge rclk);
      if (s.rst) pg = '0;
      w = {e.gnt, e.qs0, e.qs1l, e.sh, e.qs0 | e.sh, pg, e.err};
      pg = e.gnt;
      vectors++;
      if (obs !== w) begin
        miscompares++;
        $display("FAIL round_robin c%0d: got %h want %h", c, obs, w);
      end
      c++;
    end
  endtask

  task automatic test_atomic();
    stim_t s; exp_t e; logic [30:0] w; logic [4:0] pg = '0; int c = 0;
    row(0, 5'h04, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h04, 5'h1f, 5'h00, 0);
    row(0, 5'h0a, 5'h02, 0, 5'h04, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h02, 5'h00, 0, 5'h00, 5'h0a, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h08, 5'h00, 5'h1d, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h02, 5'h00, 5'h1f, 5'h02, 0);
    row(0, 5'h00, 5'h00, 0, 5'h02, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    while (stq.size() > 0) begin
      s = stq.pop_front(); e = sbq.pop_front();
      @(posedge rclk); #1;
      arst_l = ~s.rst;
      bus.spc_pcx_req_pq = s.req;
      bus.spc_pcx_atom_pq = s.atom;
      bus.sctag_pcx_stall_pq = s.stall;
      @(negedge rclk);
      if (s.rst) pg = '0;
      w = {e.gnt, e.qs0, e.qs1l, e.sh, e.qs0 | e.sh, pg, e.err};
      pg = e.gnt;
      vectors++;
      if (obs !== w) begin
        miscompares++;
        $display("FAIL atomic c%0d: got %h want %h", c, obs, w);
      end
      c++;
    end
  endtask

  task automatic test_stall();
    stim_t s; exp_t e; logic [30:0] w; logic [4:0] pg = '0; int c = 0;
    row(0, 5'h01, 5'h00, 1, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 1, 5'h00, 5'h01, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 1, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h01, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    while (stq.size() > 0) begin
      s = stq.pop_front(); e = sbq.pop_front();
      @(posedge rclk); #1;
      arst_l = ~s.rst;
      bus.spc_pcx_req_pq = s.req;
      bus.spc_pcx_atom_pq = s.atom;
      bus.sctag_pcx_stall_pq = s.stall;
      @(negedge rclk);
      if (s.rst) pg = '0;
      w = {e.gnt, e.qs0, e.qs1l, e.sh, e.qs0 | e.sh, pg, e.err};
      pg = e.gnt;
      vectors++;
      if (obs !== w) begin
        miscompares++;
        $display("FAIL stall c%0d: got %h want %h", c, obs, w);
      end
      c++;
    end
  endtask

  task automatic test_overflow();
    stim_t s; exp_t e; logic [30:0] w; logic [4:0] pg = '0; int c = 0;
    row(0, 5'h00, 5'h00, 1, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h01, 5'h00, 1, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h01, 5'h00, 1, 5'h00, 5'h01, 5'h1f, 5'h00, 0);
    row(0, 5'h01, 5'h00, 1, 5'h00, 5'h00, 5'h1e, 5'h00, 0);
    row(0, 5'h00, 5'h00, 1, 5'h00, 5'h00, 5'h1e, 5'h00, 0);
    row(0, 5'h00, 5'h00, 1, 5'h00, 5'h00, 5'h1f, 5'h00, ERR_ON);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, ERR_ON);
    row(0, 5'h00, 5'h00, 0, 5'h01, 5'h00, 5'h1f, 5'h01, ERR_ON);
    row(0, 5'h00, 5'h00, 0, 5'h01, 5'h00, 5'h1f, 5'h00, ERR_ON);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, ERR_ON);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, ERR_ON);
    while (stq.size() > 0) begin
      s = stq.pop_front(); e = sbq.pop_front();
      @(posedge rclk); #1;
      arst_l = ~s.rst;
      bus.spc_pcx_req_pq = s.req;
      bus.spc_pcx_atom_pq = s.atom;
      bus.sctag_pcx_stall_pq = s.stall;
      @(negedge rclk);
      if (s.rst) pg = '0;
      w = {e.gnt, e.qs0, e.qs1l, e.sh, e.qs0 | e.sh, pg, e.err};
      pg = e.gnt;
      vectors++;
      if (obs !== w) begin
        miscompares++;
        $display("FAIL overflow c%0d: got %h want %h", c, obs, w);
      end
      c++;
    end
  endtask

  task automatic test_reset_mid_atomic();
    stim_t s; exp_t e; logic [30:0] w; logic [4:0] pg = '0; int c = 0;
    row(0, 5'h01, 5'h01, 0, 5'h00, 5'h00, 5'h1f, 5'h00, ERR_ON);
    row(0, 5'h01, 5'h00, 0, 5'h00, 5'h01, 5'h1f, 5'h00, ERR_ON);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1e, 5'h00, ERR_ON);
    row(0, 5'h00, 5'h00, 0, 5'h01, 5'h00, 5'h1f, 5'h01, ERR_ON);
    row(1, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h0a, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h0a, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h02, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h08, 5'h00, 5'h1f, 5'h00, 0);
    row(0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 5'h1f, 5'h00, 0);
    while (stq.size() > 0) begin
      s = stq.pop_front(); e = sbq.pop_front();
      @(posedge rclk); #1;
      arst_l = ~s.rst;
      bus.spc_pcx_req_pq = s.req;
      bus.spc_pcx_atom_pq = s.atom;
      bus.sctag_pcx_stall_pq = s.stall;
      @(negedge rclk);
      if (s.rst) pg = '0;
      w = {e.gnt, e.qs0, e.qs1l, e.sh, e.qs0 | e.sh, pg, e.err};
      pg = e.gnt;
      vectors++;
      if (obs !== w) begin
        miscompares++;
        $display("FAIL reset_mid_atomic c%0d: got %h want %h", c, obs, w);
      end
      c++;
    end
  endtask

  initial begin
    bus.spc_pcx_req_pq = '0;
    bus.spc_pcx_atom_pq = '0;
    bus.sctag_pcx_stall_pq = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_atomic();
    test_stall();
    test_overflow();
    test_reset_mid_atomic();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end
endmodule
